// File: rtl/mod_74x08_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mod_74x08_pkg
//  Brief    : Shared constants, types and helpers for the triple 2-input AND
//             block modelled on three sections of a 74x08 package.
//  Revision : 1.0  initial release
// ============================================================================
package mod_74x08_pkg;

   // Number of AND sections carried by this block (gate 1 = bit index 0).
   localparam int NGATES = 3;

   // Default width of the per-gate statistics counters.
   localparam int CNT_W = 8;

   // Gate vector, ascending index so that a literal 3'b100 addresses gate 1.
   typedef logic [0:NGATES-1] gate_vec_t;

   // Single-section AND; plain operator semantics so X/Z propagate as usual.
   function automatic logic and2(input logic a, input logic b);
      return a & b;
   endfunction

endpackage : mod_74x08_pkg
`default_nettype wire

// File: rtl/and2_cell.sv
`default_nettype none
// ============================================================================
//  Module   : and2_cell
//  Brief    : One 2-input AND section: zero-latency combinational output plus
//             a flopped copy with asynchronous active-low reset.
//  Revision : 1.0  initial release
// ============================================================================
module and2_cell
   import mod_74x08_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   output logic y,
   output logic y_q
);

   logic w_y;
   logic r_y_q;

   // Combinational AND; independent of clk and rst_n.
   always_comb begin
      w_y = and2(a, b);
   end

   // Registered copy of the AND result, cleared immediately by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y_q <= 1'b0;
      end else begin
         r_y_q <= w_y;
      end
   end

   assign y   = w_y;
   assign y_q = r_y_q;

endmodule : and2_cell
`default_nettype wire

// File: rtl/mod_74x08_3.sv
`default_nettype none
// ============================================================================
//  Module   : mod_74x08_3
//  Brief    : Three independent 2-input AND gates (74x08 style) with a
//             combinational output Y and a registered copy Y_q.
//             Optional per-gate "output high" saturating cycle counters are
//             built when MOD_74X08_3_STATS_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module mod_74x08_3 #(
   parameter int NGATES = mod_74x08_pkg::NGATES
`ifdef MOD_74X08_3_STATS_EN
   ,
   parameter int CNT_W  = mod_74x08_pkg::CNT_W
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [0:NGATES-1] A,
   input  logic [0:NGATES-1] B,
   output logic [0:NGATES-1] Y,
   output logic [0:NGATES-1] Y_q
`ifdef MOD_74X08_3_STATS_EN
   ,
   input  logic                          stat_clr,
   output logic [0:NGATES-1][CNT_W-1:0]  stat_hi_cnt
`endif
);

   import mod_74x08_pkg::*;

   // The block is a fixed three-section part; reject any other width.
   if (NGATES != 3) begin : g_bad_ngates
      $error("mod_74x08_3: NGATES must be 3");
   end

   logic [0:NGATES-1] w_y;
   logic [0:NGATES-1] w_y_q;

   // One AND section per gate; each only sees its own A/B pair.
   for (genvar g = 0; g < NGATES; g++) begin : g_gate
      and2_cell u_and2 (
         .clk   (clk),
         .rst_n (rst_n),
         .a     (A[g]),
         .b     (B[g]),
         .y     (w_y[g]),
         .y_q   (w_y_q[g])
      );
   end

   assign Y   = w_y;
   assign Y_q = w_y_q;

`ifdef MOD_74X08_3_STATS_EN
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   // Per-gate count of clock edges at which the gate output was high.
   for (genvar g = 0; g < NGATES; g++) begin : g_stat
      logic [CNT_W-1:0] r_hi_cnt;

      // Saturating counter; a same-cycle clear takes priority over counting.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_hi_cnt <= '0;
         end else if (stat_clr) begin
            r_hi_cnt <= '0;
         end else if ((w_y[g] == 1'b1) && (r_hi_cnt != c_cnt_max)) begin
            r_hi_cnt <= r_hi_cnt + c_cnt_one;
         end
      end

      assign stat_hi_cnt[g] = r_hi_cnt;
   end
`endif

endmodule : mod_74x08_3
`default_nettype wire

// File: tb/tb_mod_74x08_3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_74x08_3
//  Brief    : Directed self-checking bench for mod_74x08_3 (combinational
//             AND, registered copy, async reset and, when
//             MOD_74X08_3_STATS_EN is defined, the statistics counters).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mod_74x08_3;

   logic       clk;
   logic       clk_en;
   logic       rst_n;
   logic [0:2] A;
   logic [0:2] B;
   logic [0:2] Y;
   logic [0:2] Y_q;
`ifdef MOD_74X08_3_STATS_EN
   logic             stat_clr;
   logic [0:2][7:0]  stat_hi_cnt;
`endif

   int n_vec;
   int n_err;

   mod_74x08_3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .Y     (Y),
      .Y_q   (Y_q)
`ifdef MOD_74X08_3_STATS_EN
      ,
      .stat_clr    (stat_clr),
      .stat_hi_cnt (stat_hi_cnt)
`endif
   );

   // Gated clock so combinational checks can run with no clock activity.
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic chk3(input string tag, input logic [0:2] obs, input logic [0:2] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic comb(input string tag, input logic [0:2] a, input logic [0:2] b,
                       input logic [0:2] exp);
      A = a;
      B = b;
      #20;
      chk3(tag, Y, exp);
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      clk    = 1'b0;
      clk_en = 1'b0;
      rst_n  = 1'b1;
      A      = 3'b000;
      B      = 3'b000;
`ifdef MOD_74X08_3_STATS_EN
      stat_clr = 1'b0;
`endif
      #1;
      rst_n = 1'b0;
      #1;
      chk3("reset_yq", Y_q, 3'b000);
      chk3("reset_y", Y, 3'b000);

      // Per-gate truth tables, no clock running.
      comb("g1_11", 3'b100, 3'b100, 3'b100);
      comb("g1_01", 3'b000, 3'b100, 3'b000);
      comb("g1_10", 3'b100, 3'b000, 3'b000);
      comb("g1_00", 3'b000, 3'b000, 3'b000);
      comb("g2_11", 3'b010, 3'b010, 3'b010);
      comb("g2_01", 3'b000, 3'b010, 3'b000);
      comb("g2_10", 3'b010, 3'b000, 3'b000);
      comb("g2_00", 3'b000, 3'b000, 3'b000);
      comb("g3_11", 3'b001, 3'b001, 3'b001);
      comb("g3_01", 3'b000, 3'b001, 3'b000);
      comb("g3_10", 3'b001, 3'b000, 3'b000);
      comb("g3_00", 3'b000, 3'b000, 3'b000);

      // Combined gates / independence.
      comb("mix_a", 3'b111, 3'b101, 3'b101);
      comb("mix_b", 3'b011, 3'b110, 3'b010);

      // X propagation: 1&X = X, 0&X = 0.
      comb("x_one",  3'b1x0, 3'b111, 3'b1x0);
      comb("x_zero", 3'b1x0, 3'b000, 3'b000);

      chk3("yq_held_in_reset", Y_q, 3'b000);

      // Registered path.
      A = 3'b111;
      B = 3'b111;
      rst_n = 1'b1;
      #1;
      chk3("yq_no_edge_yet", Y_q, 3'b000);
      clk_en = 1'b1;
      @(posedge clk); #1;
      chk3("yq_first_edge", Y_q, 3'b111);
      A = 3'b010;
      #1;
      chk3("yq_mid_cycle_hold", Y_q, 3'b111);
      chk3("y_mid_cycle", Y, 3'b010);
      @(posedge clk); #1;
      chk3("yq_second_edge", Y_q, 3'b010);
      A = 3'b111;
      @(posedge clk); #1;
      chk3("yq_third_edge", Y_q, 3'b111);

      // Asynchronous reset pulse mid-cycle.
      #1;
      rst_n = 1'b0;
      #1;
      chk3("yq_async_clear", Y_q, 3'b000);
      chk3("y_during_reset", Y, 3'b111);
`ifdef MOD_74X08_3_STATS_EN
      chk8("cnt0_async_clear", stat_hi_cnt[0], 8'd0);
`endif
      @(posedge clk); #1;
      chk3("yq_reset_held", Y_q, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk3("yq_after_release", Y_q, 3'b111);

`ifdef MOD_74X08_3_STATS_EN
      // Clear, then count with only gate 1 high.
      A = 3'b100;
      B = 3'b100;
      stat_clr = 1'b1;
      @(posedge clk); #1;
      stat_clr = 1'b0;
      chk8("cnt0_clear_wins", stat_hi_cnt[0], 8'd0);
      chk8("cnt1_clear", stat_hi_cnt[1], 8'd0);
      chk8("cnt2_clear", stat_hi_cnt[2], 8'd0);
      repeat (10) @(posedge clk);
      #1;
      chk8("cnt0_ten", stat_hi_cnt[0], 8'd10);
      repeat (290) @(posedge clk);
      #1;
      chk8("cnt0_saturated", stat_hi_cnt[0], 8'd255);
      chk8("cnt1_idle", stat_hi_cnt[1], 8'd0);
      chk8("cnt2_idle", stat_hi_cnt[2], 8'd0);
      stat_clr = 1'b1;
      @(posedge clk); #1;
      stat_clr = 1'b0;
      chk8("cnt0_final_clear", stat_hi_cnt[0], 8'd0);
      chk8("cnt1_final_clear", stat_hi_cnt[1], 8'd0);
      chk8("cnt2_final_clear", stat_hi_cnt[2], 8'd0);
`endif

      clk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_mod_74x08_3
`default_nettype wire
